// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared types, ALU/opcode encodings and decode helpers for the ARM32 controller
package arm_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH, FETCH_WAIT, DECODE, EXECUTE, MEMORY, MEMORY_WAIT, WRITE_BACK
    } state_e;

    typedef enum logic [3:0] {
        EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
    } cond_e;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;
    localparam logic [2:0] ALU_MOV = 3'd5;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;

    localparam logic [3:0] REG_LR = 4'd14;

    typedef struct packed {
        logic [3:0]  a_addr;
        logic [3:0]  b_addr;
        logic [3:0]  shift_addr;
        logic [3:0]  w_addr1;
        logic [3:0]  w_addr2;
        logic        en_a;
        logic        en_b;
        logic        en_s;
        logic        sel_shift;
        logic        sel_b;
        logic [1:0]  sel_a_in;
        logic [1:0]  shift_op;
        logic [4:0]  shift_imme;
        logic [31:0] imme_data;
        logic [2:0]  alu_op;
        logic        w_en1;
        logic        w_en2;
        logic        en_status1;
        logic        en_status2;
        logic        sel_w_data;
    } ctrl_t;

    // returns {supported, alu_op}; unsupported opcodes execute as a NOP
    function automatic logic [3:0] dp_decode(logic [3:0] op);
        case (op)
            OP_ADD:  return {1'b1, ALU_ADD};
            OP_SUB:  return {1'b1, ALU_SUB};
            OP_CMP:  return {1'b1, ALU_SUB};
            OP_AND:  return {1'b1, ALU_AND};
            OP_ORR:  return {1'b1, ALU_ORR};
            OP_EOR:  return {1'b1, ALU_EOR};
            OP_MOV:  return {1'b1, ALU_MOV};
            default: return 4'b0;
        endcase
    endfunction

    // imm8 rotated right by twice the 4-bit rotate field
    function automatic logic [31:0] rot_imm(logic [11:0] f);
        logic [63:0] d;
        d = {2{24'b0, f[7:0]}} >> {f[11:8], 1'b0};
        return d[31:0];
    endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: ARM condition code check of cond[3:0] against NZCV flags
// Ports: cond (condition field), nzcv (flags N,Z,C,V msb first), pass (instruction executes)
module cond_eval
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            EQ: pass = z;
            NE: pass = !z;
            CS: pass = c;
            CC: pass = !c;
            MI: pass = n;
            PL: pass = !n;
            VS: pass = v;
            VC: pass = !v;
            HI: pass = c && !z;
            LS: pass = !c || z;
            GE: pass = n == v;
            LT: pass = n != v;
            GT: pass = !z && (n == v);
            LE: pass = z || (n != v);
            AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/controller.sv
// controller: multi-cycle ARM32 control FSM driving the datapath control bundle and owning the PC
// Ports: clk, rst (sync active-high), instr (instruction RAM data), status_in (NZCV in [31:28]),
//        pc (instruction address), ctrl (datapath control bundle), ram_w_en (STR strobe),
//        state_out (current state for debug)
// Build option: CTRL_BL_EN adds a link write-back (r14 = pc+4) for branch-with-link.
module controller
    import arm_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0,
    parameter int          IMEM_WAIT = 1,
    parameter int          DMEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] status_in,
    output logic [31:0] pc,
    output ctrl_t       ctrl,
    output logic        ram_w_en,
    output logic [2:0]  state_out
);
    state_e      state, state_nx;
    logic [31:0] ir, pc_nx, pc4, br_tgt;
    logic [7:0]  cnt;
    logic [3:0]  dp_dec;
    logic        pass, dp, mem, br, bl, ldr, dp_ok, is_cmp, we;
    ctrl_t       c;
    logic        unused_status;

    assign unused_status = ^status_in[27:0];

    cond_eval u_cond (
        .cond (ir[31:28]),
        .nzcv (status_in[31:28]),
        .pass (pass)
    );

    assign dp     = ir[27:26] == 2'b00;
    assign mem    = ir[27:26] == 2'b01;
    assign br     = ir[27:25] == 3'b101;
    assign ldr    = mem && ir[20];
    assign dp_dec = dp_decode(ir[24:21]);
    assign dp_ok  = dp && dp_dec[3];
    assign is_cmp = dp && ir[24:21] == OP_CMP;
    assign pc4    = pc + 32'd4;
    assign br_tgt = pc + 32'd8 + {{6{ir[23]}}, ir[23:0], 2'b00};
`ifdef CTRL_BL_EN
    assign bl = br && ir[24];
`else
    assign bl = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= PC_RESET;
            ir    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (state == FETCH)
                cnt <= 8'(IMEM_WAIT - 1);
            else if (state == MEMORY)
                cnt <= 8'(DMEM_WAIT - 1);
            else if (cnt != '0)
                cnt <= cnt - 8'd1;
            if (state == FETCH_WAIT && cnt == '0)
                ir <= instr;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        c        = '0;
        we       = 1'b0;
        case (state)
            FETCH: state_nx = FETCH_WAIT;
            FETCH_WAIT: state_nx = cnt == '0 ? DECODE : FETCH_WAIT;
            DECODE: begin
                if (pass && (dp || mem || br)) begin
                    state_nx = EXECUTE;
                    if (dp || mem) begin
                        c.a_addr     = ir[19:16];
                        c.b_addr     = ir[3:0];
                        c.en_a       = 1'b1;
                        c.en_b       = 1'b1;
                        c.en_s       = 1'b1;
                        c.sel_shift  = ir[4];
                        c.shift_addr = ir[4] ? ir[11:8] : 4'd0;
                        c.shift_imme = ir[4] ? 5'd0 : ir[11:7];
                    end
                end else begin
                    state_nx = FETCH;
                    pc_nx    = pc4;
                end
            end
            EXECUTE: begin
                if (br) begin
                    state_nx = bl ? WRITE_BACK : FETCH;
                    pc_nx    = bl ? pc : br_tgt;
                end else if (mem) begin
                    c.sel_b     = 1'b1;
                    c.imme_data = {20'b0, ir[11:0]};
                    c.alu_op    = ir[23] ? ALU_ADD : ALU_SUB;
                    state_nx    = MEMORY;
                end else if (dp_ok) begin
                    c.shift_op   = ir[6:5];
                    c.alu_op     = dp_dec[2:0];
                    c.sel_b      = ir[25];
                    c.imme_data  = ir[25] ? rot_imm(ir[11:0]) : 32'd0;
                    c.en_status1 = ir[20] || is_cmp;
                    state_nx     = is_cmp ? FETCH : WRITE_BACK;
                    pc_nx        = is_cmp ? pc4 : pc;
                end else begin
                    state_nx = FETCH;
                    pc_nx    = pc4;
                end
            end
            MEMORY: begin
                we       = !ir[20];
                state_nx = MEMORY_WAIT;
            end
            MEMORY_WAIT: begin
                if (cnt == '0) begin
                    state_nx = ldr ? WRITE_BACK : FETCH;
                    pc_nx    = ldr ? pc : pc4;
                end
            end
            WRITE_BACK: begin
                c.w_en1  = 1'b1;
                state_nx = FETCH;
                if (br) begin
                    c.w_addr1   = REG_LR;
                    c.sel_a_in  = 2'b01;
                    c.sel_b     = 1'b1;
                    c.imme_data = 32'd4;
                    c.alu_op    = ALU_ADD;
                    pc_nx       = br_tgt;
                end else begin
                    c.w_addr1    = ir[15:12];
                    c.sel_w_data = ldr;
                    pc_nx        = pc4;
                end
            end
            default: state_nx = FETCH;
        endcase
    end

    // reset forces every strobe low in the reset cycle itself, whatever state is held
    assign ctrl      = rst ? '0 : c;
    assign ram_w_en  = !rst && we;
    assign state_out = state;
endmodule

// File: tb/tb_controller.sv
// tb_controller: table-driven self-checking bench for controller
module tb_controller;
    import arm_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr, status_in, pc;
    ctrl_t       ctrl;
    logic        ram_w_en;
    logic [2:0]  state_out;
    logic [31:0] imem [64];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    assign instr = imem[pc[7:2]];

    controller dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .status_in (status_in),
        .pc        (pc),
        .ctrl      (ctrl),
        .ram_w_en  (ram_w_en),
        .state_out (state_out)
    );

    typedef struct packed {
        logic [31:0] addr, ins, st, a, b, ss, sa, si, so, alu, sb, imm, es;
        logic [31:0] wc, wa, swd, rc, wb, sela, cyc, pca;
    } vec_t;

    vec_t tbl [17];
    vec_t q [$];

    function automatic vec_t mk(int addr, int ins, int st, int a, int b, int ss, int sa, int si,
                                int so, int alu, int sb, int imm, int es, int wc, int wa, int swd,
                                int rc, int wb, int sela, int cyc, int pca);
        vec_t v;
        v = '{addr, ins, st, a, b, ss, sa, si, so, alu, sb, imm, es,
              wc, wa, swd, rc, wb, sela, cyc, pca};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] ins, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s instr=%h got=%h expected=%h", name, ins, act, exp);
        end
    endtask

    task automatic run(input vec_t e, output vec_t o);
        int n;
        n = 0;
        o = '0;
        status_in = e.st;
        do begin
            if (state_out == DECODE) begin
                o.a  = 32'(ctrl.a_addr);
                o.b  = 32'(ctrl.b_addr);
                o.ss = 32'(ctrl.sel_shift);
                o.sa = 32'(ctrl.shift_addr);
                o.si = 32'(ctrl.shift_imme);
            end
            if (state_out == EXECUTE) begin
                o.so  = 32'(ctrl.shift_op);
                o.alu = 32'(ctrl.alu_op);
                o.sb  = 32'(ctrl.sel_b);
                o.imm = ctrl.imme_data;
                o.es  = 32'(ctrl.en_status1);
            end
            if (ctrl.w_en1) begin
                o.wc  = o.wc + 1;
                o.wa  = 32'(ctrl.w_addr1);
                o.swd = 32'(ctrl.sel_w_data);
            end
            o.rc = o.rc + 32'(ram_w_en);
            if (state_out == WRITE_BACK) begin
                o.wb   = 1;
                o.sela = 32'(ctrl.sel_a_in);
            end
            n++;
            @(negedge clk);
        end while (state_out != FETCH && n < 40);
        o.cyc = 32'(n);
        o.pca = pc;
    endtask

    initial begin
        vec_t e, o;
        int   wcnt, n;
        status_in = 32'h0;
        tbl[0]  = mk('h00, 'hE3A01005, 0, 0, 5, 0, 0, 0, 0, 5, 1, 5, 0, 1, 1, 0, 0, 1, 0, 5, 'h04);
        tbl[1]  = mk('h04, 'hE0812001, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0, 5, 'h08);
        tbl[2]  = mk('h08, 'h1A000002, 'h40000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 'h0C);
        tbl[3]  = mk('h0C, 'hE1510002, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4, 'h10);
        tbl[4]  = mk('h10, 'h0A000002, 'h40000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 'h20);
        tbl[5]  = mk('h20, 'hE5812004, 0, 1, 4, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 1, 0, 0, 6, 'h24);
        tbl[6]  = mk('h24, 'hE5913008, 0, 1, 8, 0, 0, 0, 0, 0, 1, 8, 0, 1, 3, 1, 0, 1, 0, 7, 'h28);
        tbl[7]  = mk('h28, 'hE5113004, 0, 1, 4, 0, 0, 0, 0, 1, 1, 4, 0, 1, 3, 1, 0, 1, 0, 7, 'h2C);
        tbl[8]  = mk('h2C, 'hE3810CFF, 0, 1, 15, 1, 12, 0, 3, 3, 1, 'hFF00, 0, 1, 0, 0, 0, 1, 0, 5, 'h30);
        tbl[9]  = mk('h30, 'hE0312153, 0, 1, 3, 1, 1, 0, 2, 4, 0, 0, 1, 1, 2, 0, 0, 1, 0, 5, 'h34);
        tbl[10] = mk('h34, 'hE04541A6, 0, 5, 6, 0, 0, 3, 1, 1, 0, 0, 0, 1, 4, 0, 0, 1, 0, 5, 'h38);
        tbl[11] = mk('h38, 'hE1110002, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 'h3C);
        tbl[12] = mk('h3C, 'hEC000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 'h40);
`ifdef CTRL_BL_EN
        tbl[13] = mk('h40, 'hEB000001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14, 0, 0, 1, 1, 5, 'h4C);
`else
        tbl[13] = mk('h40, 'hEB000001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 'h4C);
`endif
        tbl[14] = mk('h4C, 'hF0812001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 'h50);
        tbl[15] = mk('h50, 'hEAFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 'h54);
        tbl[16] = mk('h54, 'h13A0100A, 0, 0, 10, 0, 0, 0, 0, 5, 1, 10, 0, 1, 1, 0, 0, 1, 0, 5, 'h58);
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        for (int i = 0; i < 17; i++) imem[tbl[i].addr[7:2]] = tbl[i].ins;

        repeat (2) @(negedge clk);
        chk("rst_state", 0, 32'(state_out), 32'(FETCH));
        chk("rst_pc", 0, pc, 32'h0);
        chk("rst_ctrl_zero", 0, 32'(ctrl != '0), 0);
        chk("rst_ram_w_en", 0, 32'(ram_w_en), 0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            chk("pc_start", tbl[i].ins, pc, tbl[i].addr);
            q.push_back(tbl[i]);
            run(tbl[i], o);
            e = q.pop_front();
            chk("a_addr", e.ins, o.a, e.a);
            chk("b_addr", e.ins, o.b, e.b);
            chk("sel_shift", e.ins, o.ss, e.ss);
            chk("shift_addr", e.ins, o.sa, e.sa);
            chk("shift_imme", e.ins, o.si, e.si);
            chk("shift_op", e.ins, o.so, e.so);
            chk("alu_op", e.ins, o.alu, e.alu);
            chk("sel_b", e.ins, o.sb, e.sb);
            chk("imme_data", e.ins, o.imm, e.imm);
            chk("en_status1", e.ins, o.es, e.es);
            chk("w_en1_cycles", e.ins, o.wc, e.wc);
            chk("w_addr1", e.ins, o.wa, e.wa);
            chk("sel_w_data", e.ins, o.swd, e.swd);
            chk("ram_w_en_cycles", e.ins, o.rc, e.rc);
            chk("wb_visited", e.ins, o.wb, e.wb);
            chk("sel_a_in", e.ins, o.sela, e.sela);
            chk("cycles", e.ins, o.cyc, e.cyc);
            chk("pc_after", e.ins, o.pca, e.pca);
        end

        // reset arriving in MEMORY_WAIT of an LDR
        imem[0] = 32'hE5913008;
        status_in = 32'h0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wcnt = 0;
        n = 0;
        while (state_out != MEMORY_WAIT && n < 20) begin
            wcnt += 32'(ctrl.w_en1);
            n++;
            @(negedge clk);
        end
        chk("reach_mem_wait", 0, 32'(state_out), 32'(MEMORY_WAIT));
        rst = 1'b1;
        #1;
        chk("rst_mw_w_en1", 0, 32'(ctrl.w_en1), 0);
        chk("rst_mw_ram_w_en", 0, 32'(ram_w_en), 0);
        @(negedge clk);
        wcnt += 32'(ctrl.w_en1);
        chk("rst_mw_state", 0, 32'(state_out), 32'(FETCH));
        chk("rst_mw_pc", 0, pc, 32'h0);
        chk("rst_mw_w_en1_seen", 0, 32'(wcnt), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
